// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family: FSM encodings and default sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } adder_state_t;

    localparam int ADDER_WIDTH = 8;
    localparam int ADDER_CNT_W = 4;

endpackage

// File: rtl/gate_full_adder.sv
// One-bit full adder built only from library gates: s = a^b^ci, co = a&b | ci&(a^b).
module gate_full_adder (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);
    logic ab_x;
    logic ab_a;
    logic c_p;

    my_xor u_x1 (.y(ab_x), .a(a),    .b(b));
    my_xor u_x2 (.y(s),    .a(ab_x), .b(ci));
    my_and u_a1 (.y(ab_a), .a(a),    .b(b));
    my_and u_a2 (.y(c_p),  .a(ci),   .b(ab_x));
    my_or  u_o1 (.y(co),   .a(ab_a), .b(c_p));
endmodule

// File: rtl/gate_lib.sv
// NOR-based gate library: every gate below is composed purely of two-input NORs.
module my_nor (
    output logic y,
    input  logic a,
    input  logic b
);
    assign y = ~(a | b);
endmodule

module my_or (
    output logic y,
    input  logic a,
    input  logic b
);
    logic n;
    my_nor u_n0 (.y(n), .a(a), .b(b));
    my_nor u_n1 (.y(y), .a(n), .b(n));
endmodule

module my_and (
    output logic y,
    input  logic a,
    input  logic b
);
    logic na;
    logic nb;
    my_nor u_na (.y(na), .a(a), .b(a));
    my_nor u_nb (.y(nb), .a(b), .b(b));
    my_nor u_y  (.y(y),  .a(na), .b(nb));
endmodule

module my_xor (
    output logic y,
    input  logic a,
    input  logic b
);
    logic n1;
    logic n2;
    logic n3;
    logic xn;
    // Classic four-NOR XNOR, then one more NOR as an inverter.
    my_nor u_n1 (.y(n1), .a(a),  .b(b));
    my_nor u_n2 (.y(n2), .a(a),  .b(n1));
    my_nor u_n3 (.y(n3), .a(b),  .b(n1));
    my_nor u_xn (.y(xn), .a(n2), .b(n3));
    my_nor u_y  (.y(y),  .a(xn), .b(xn));
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full adder reused LSB-first over WIDTH cycles, start/done handshake.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CNT_W = ADDER_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    adder_state_t     state;
    adder_state_t     next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] counter;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    assign last_bit = (counter == CNT_W'(WIDTH - 1));

    gate_full_adder u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // sum_sr and carry double as the held result: nothing touches them between DONE and the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            counter <= '0;
        end else if (state == IDLE && start) begin
            a_sr    <= a;
            b_sr    <= b;
            sum_sr  <= '0;
            carry   <= cin;
            counter <= '0;
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
            carry   <= fa_co;
            counter <= counter + CNT_W'(1);
        end
    end

    assign sum  = sum_sr;
    assign cout = carry;

`ifdef ADDER_OVF_EN
    logic ovf_q;

    // On the final bit, carry still holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf_q <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            ovf_q <= carry ^ fa_co;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
